// File: rtl/uart_rx_mm.sv
// uart_rx_mm: 8N1 serial receiver with a receive FIFO behind a small
// register port. Host reads data, status and fill level, and clears
// the sticky error flags.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | line idle, waiting for rx_s low
// S_START | timing to mid start bit, rejects glitches
// S_DATA  | sampling 8 data bits, LSB first, one per bit period
// S_STOP  | sampling the stop bit, push byte or flag framing error
// S_BRK   | line held low after a framing error, wait for idle high
`timescale 1ns/1ps
module uart_rx_mm #(
  parameter int CLKS_PER_BIT = 10,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rx_i,
  input  logic [1:0] addr_i,
  input  logic       rd_en_i,
  input  logic       wr_en_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic       irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BRK   = 3'd4;

  logic          rx_meta_q, rx_s_q;
  logic [2:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          push, ferr_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          full, not_empty, pop, push_ok, ovr_set, sts_wr;
  logic          ferr_q, ferr_d, ovr_q, ovr_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q;
  logic [7:0]    count_ext;
  logic          unused_wr_bits;

  assign unused_wr_bits = ^{wr_data_i[7:4], wr_data_i[1:0]};

  // two-flop synchroniser, idle-high reset so no false start edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  // receive FSM: down-counting bit timer, sample when it reaches zero
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          bitcnt_d = '0;
          timer_d  = HALF_LOAD;
          state_d  = S_START;
        end
      end
      S_START: begin
        if (timer_q == '0) begin
          if (!rx_s_q) begin
            timer_d = BIT_LOAD;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_DATA: begin
        if (timer_q == '0) begin
          shift_d = {rx_s_q, shift_q[7:1]};
          timer_d = BIT_LOAD;
          if (bitcnt_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bitcnt_d = bitcnt_q + 3'd1;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_STOP: begin
        if (timer_q == '0) begin
          if (rx_s_q) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_set = 1'b1;
            state_d  = S_BRK;
          end
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      S_BRK: begin
        if (rx_s_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // receive FSM registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      timer_q  <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      bitcnt_q <= bitcnt_d;
      shift_q  <= shift_d;
    end
  end

  assign full      = (count_q == FULL_CNT);
  assign not_empty = (count_q != '0);
  assign pop       = rd_en_i && (addr_i == 2'd0) && not_empty;
  // a pop in the same cycle frees a slot, so a full FIFO still accepts
  assign push_ok   = push && (!full || pop);
  assign ovr_set   = push && full && !pop;
  assign sts_wr    = wr_en_i && (addr_i == 2'd1);

  // FIFO pointer/occupancy and sticky flag next state (set beats clear)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    ferr_d = ferr_set | (ferr_q & ~(sts_wr & wr_data_i[3]));
    ovr_d  = ovr_set  | (ovr_q  & ~(sts_wr & wr_data_i[2]));
  end

  // FIFO storage, no reset needed since occupancy guards every read
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= shift_q;
  end

  // FIFO control and flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  // zero-extend occupancy for the COUNT register
  always_comb begin
    count_ext          = '0;
    count_ext[CW-1:0]  = count_q;
  end

  // read mux; rd_data holds its last value between reads
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en_i) begin
      case (addr_i)
        2'd0:    rd_data_d = not_empty ? mem_q[rd_ptr_q] : 8'h00;
        2'd1:    rd_data_d = {4'b0000, ferr_q, ovr_q, full, not_empty};
        2'd2:    rd_data_d = count_ext;
        default: rd_data_d = 8'h00;
      endcase
    end
  end

  // registered read port
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_en_i;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign irq_o      = not_empty;

endmodule
